// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, selectable bit order and frame markers.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pi_valid,
    input  logic [WIDTH-1:0] pi,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
`ifndef PISO_PARITY_EN
    localparam logic [CW-1:0]  CNT_TWO  = CW'(2);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_so;
    logic             r_soValid;
    logic             r_frameStart;
    logic             r_done;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    logic             w_lastCycle;
    logic             w_ready;
    logic             w_accept;
    logic             w_firstBit;
    logic             w_nextBit;
    logic [WIDTH-1:0] w_shifted;

    // The word's current bit always sits at the outgoing end of r_shift, so the next bit is one place in.
    assign w_firstBit = MSB_FIRST ? pi[WIDTH-1] : pi[0];
    assign w_nextBit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
    assign w_shifted  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    assign w_lastCycle = (r_state == PARITY);
`else
    assign w_lastCycle = (r_state == SHIFT) && (r_cnt == CNT_ONE);
`endif

    assign w_ready  = reset && ((r_state == IDLE) || w_lastCycle);
    assign w_accept = pi_valid && w_ready;

    // A load in the final-bit cycle wins over the decrement, which is what makes frames gapless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_so         <= IDLE_LEVEL;
            r_soValid    <= 1'b0;
            r_frameStart <= 1'b0;
            r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_frameStart <= 1'b0;
            r_done       <= 1'b0;
            if (w_accept) begin
                r_state      <= SHIFT;
                r_cnt        <= CNT_LOAD;
                r_shift      <= pi;
                r_so         <= w_firstBit;
                r_soValid    <= 1'b1;
                r_frameStart <= 1'b1;
`ifdef PISO_PARITY_EN
                r_parity     <= ^pi;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_so      <= IDLE_LEVEL;
                        r_soValid <= 1'b0;
                    end
                    SHIFT: begin
                        if (r_cnt > CNT_ONE) begin
                            r_shift <= w_shifted;
                            r_cnt   <= r_cnt - CNT_ONE;
                            r_so    <= w_nextBit;
`ifndef PISO_PARITY_EN
                            r_done  <= (r_cnt == CNT_TWO);
`endif
                        end else begin
                            r_cnt   <= '0;
                            r_shift <= '0;
`ifdef PISO_PARITY_EN
                            r_state <= PARITY;
                            r_so    <= r_parity;
                            r_done  <= 1'b1;
`else
                            r_state   <= IDLE;
                            r_so      <= IDLE_LEVEL;
                            r_soValid <= 1'b0;
`endif
                        end
                    end
`ifdef PISO_PARITY_EN
                    PARITY: begin
                        r_state   <= IDLE;
                        r_so      <= IDLE_LEVEL;
                        r_soValid <= 1'b0;
                    end
`endif
                    default: begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_so      <= IDLE_LEVEL;
                        r_soValid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pi_ready    = w_ready;
    assign so          = r_so;
    assign so_valid    = r_soValid;
    assign frame_start = r_frameStart;
    assign done        = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/idle-0 and an LSB-first/idle-1 instance share one stimulus
// and are checked every cycle against a queue-of-bits model plus hand-computed literals.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = W + (PAR ? 1 : 0);
    localparam int LOGN  = 512;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         piValid = 1'b0;
    logic [W-1:0] piData = '0;

    logic readyM, soM, soValidM, fsM, doneM;
    logic readyL, soL, soValidL, fsL, doneL;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutM (
        .clk(clk), .reset(reset), .pi_valid(piValid), .pi(piData),
        .pi_ready(readyM), .so(soM), .so_valid(soValidM), .frame_start(fsM), .done(doneM)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutL (
        .clk(clk), .reset(reset), .pi_valid(piValid), .pi(piData),
        .pi_ready(readyL), .so(soL), .so_valid(soValidL), .frame_start(fsL), .done(doneL)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic bm;
        logic bl;
        logic fs;
        logic dn;
    } entry_t;

    entry_t q[$];
    entry_t cur;
    int     cyc = 0;
    int     passCount = 0;
    int     checkCount = 0;

    logic logSoM    [LOGN];
    logic logSoL    [LOGN];
    logic logValidM [LOGN];
    logic logValidL [LOGN];
    logic logFsM    [LOGN];
    logic logDoneM  [LOGN];
    logic logDoneL  [LOGN];
    logic logReady  [LOGN];

    function entry_t idleEntry();
        entry_t e;
        e.v  = 1'b0;
        e.bm = 1'b0;
        e.bl = 1'b1;
        e.fs = 1'b0;
        e.dn = 1'b0;
        return e;
    endfunction

    // The block can take a word when it is idle or emitting the frame's final bit.
    function logic modelReady();
        return reset && (!cur.v || cur.dn);
    endfunction

    task automatic pushFrame(input logic [W-1:0] d);
        entry_t e;
        for (int i = 0; i < W; i++) begin
            e.v  = 1'b1;
            e.bm = d[W-1-i];
            e.bl = d[i];
            e.fs = (i == 0);
            e.dn = (i == W - 1) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.v  = 1'b1;
            e.bm = ^d;
            e.bl = ^d;
            e.fs = 1'b0;
            e.dn = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, actual, expected);
    endtask

    // Model: each accepted word becomes a run of future per-cycle outputs.
    initial begin
        logic acc;
        cur = idleEntry();
        forever begin
            @(posedge clk);
            acc = piValid && modelReady();
            cyc++;
            if (!reset) begin
                q.delete();
                cur = idleEntry();
            end else begin
                if (acc) pushFrame(piData);
                if (q.size() > 0) cur = q.pop_front();
                else cur = idleEntry();
            end
        end
    end

    // Compare process: logs and checks both instances on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0 && cyc < LOGN) begin
                logSoM[cyc]    = soM;
                logSoL[cyc]    = soL;
                logValidM[cyc] = soValidM;
                logValidL[cyc] = soValidL;
                logFsM[cyc]    = fsM;
                logDoneM[cyc]  = doneM;
                logDoneL[cyc]  = doneL;
                logReady[cyc]  = readyM;
                checkOutput("cycleM", {11'd0, soM, soValidM, fsM, doneM, readyM},
                            {11'd0, cur.bm, cur.v, cur.fs, cur.dn, modelReady()});
                checkOutput("cycleL", {11'd0, soL, soValidL, fsL, doneL, readyL},
                            {11'd0, cur.bl, cur.v, cur.fs, cur.dn, modelReady()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d);
        piValid = v;
        piData  = d;
    endtask

    task automatic sendWord(input logic [W-1:0] d, output int k);
        applyStimulus(1'b1, d);
        k = cyc + 1;
        tick();
        applyStimulus(1'b0, '0);
    endtask

    initial begin
        int k;
        int k2;
        int kRel;
        int n;
        logic [W-1:0] lit;
        logic [W-1:0] lit2;

        // Reset held low with a word offered.
        applyStimulus(1'b1, 8'h5A);
        reset = 1'b0;
        repeat (4) tick();
        checkOutput("rstSoM", {15'd0, logSoM[3]}, 16'd0);
        checkOutput("rstSoL", {15'd0, logSoL[3]}, 16'd1);
        checkOutput("rstValid", {15'd0, logValidM[3]}, 16'd0);
        checkOutput("rstReady", {15'd0, logReady[3]}, 16'd0);
        reset = 1'b1;
        applyStimulus(1'b0, '0);
        kRel = cyc + 1;
        repeat (2) tick();
        checkOutput("relReady", {15'd0, logReady[kRel]}, 16'd1);

        // Single word A5, MSB first.
        sendWord(8'hA5, k);
        repeat (FRAME + 2) tick();
        lit = 8'hA5;
        for (int i = 0; i < W; i++) checkOutput("a5Bit", {15'd0, logSoM[k+i]}, {15'd0, lit[W-1-i]});
        checkOutput("a5Start", {14'd0, logFsM[k], logFsM[k+1]}, 16'b10);
        checkOutput("a5Done", {14'd0, logDoneM[k+FRAME-2], logDoneM[k+FRAME-1]}, 16'b01);
        checkOutput("a5Idle", {14'd0, logValidM[k+FRAME], logReady[k+FRAME]}, 16'b01);

        // Back-to-back 01 then 80 with valid held high, checked on the LSB-first instance.
        applyStimulus(1'b1, 8'h01);
        k = cyc + 1;
        tick();
        applyStimulus(1'b1, 8'h80);
        repeat (FRAME) tick();
        applyStimulus(1'b0, '0);
        repeat (FRAME + 3) tick();
        lit  = 8'h01;
        lit2 = 8'h80;
        for (int i = 0; i < W; i++) begin
            checkOutput("gapBit1", {15'd0, logSoL[k+i]}, {15'd0, lit[i]});
            checkOutput("gapBit2", {15'd0, logSoL[k+FRAME+i]}, {15'd0, lit2[i]});
        end
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) if (logValidL[k+i] === 1'b1) n++;
        checkOutput("gapValidRun", 16'(n), 16'(2 * FRAME));
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) if (logDoneL[k+i] === 1'b1) n++;
        checkOutput("gapDoneCount", 16'(n), 16'd2);
        checkOutput("gapDonePos", {14'd0, logDoneL[k+FRAME-1], logDoneL[k+2*FRAME-1]}, 16'b11);
        checkOutput("gapEnd", {15'd0, logValidL[k+2*FRAME]}, 16'd0);

        // pi churns while pi_ready is low; only 3C must come out.
        applyStimulus(1'b1, 8'h3C);
        k = cyc + 1;
        tick();
        for (int j = 0; j < FRAME - 2; j++) begin
            applyStimulus(1'b1, W'($urandom));
            tick();
        end
        applyStimulus(1'b0, W'($urandom));
        repeat (FRAME + 3) tick();
        lit = 8'h3C;
        for (int i = 0; i < W; i++) checkOutput("churnBit", {15'd0, logSoM[k+i]}, {15'd0, lit[W-1-i]});
        checkOutput("churnNoExtra", {15'd0, logValidM[k+FRAME]}, 16'd0);

        // Reset asserted during bit 4 of FF, then C3 after release.
        sendWord(8'hFF, k);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sendWord(8'hC3, k2);
        repeat (FRAME + 3) tick();
        checkOutput("abortValid", {15'd0, logValidM[k+4]}, 16'd0);
        n = 0;
        for (int i = 0; i < W; i++) if (logDoneM[k+i] === 1'b1) n++;
        checkOutput("abortNoDone", 16'(n), 16'd0);
        lit = 8'hC3;
        for (int i = 0; i < W; i++) begin
            checkOutput("postRstBitM", {15'd0, logSoM[k2+i]}, {15'd0, lit[W-1-i]});
            checkOutput("postRstBitL", {15'd0, logSoL[k2+i]}, {15'd0, lit[i]});
        end

`ifdef PISO_PARITY_EN
        // Parity frame for 07: three ones, so the ninth bit is 1.
        sendWord(8'h07, k);
        repeat (FRAME + 3) tick();
        checkOutput("parBitM", {15'd0, logSoM[k+8]}, 16'd1);
        checkOutput("parBitL", {15'd0, logSoL[k+8]}, 16'd1);
        checkOutput("parDone", {14'd0, logDoneM[k+7], logDoneM[k+8]}, 16'b01);
        n = 0;
        for (int i = 0; i < 8; i++) if (logReady[k+i] === 1'b1) n++;
        checkOutput("parReadyLow", 16'(n), 16'd0);
        checkOutput("parReadyHigh", {14'd0, logReady[k+8], logReady[k+9]}, 16'b11);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
